// File: rtl/trena_sequenciador_envio.sv
// Sends one ASCII character of the measurement frame (BCD digits, then a terminator) per transmitir pulse.
// Optional macro TIMEOUT_TX_EN adds an ESPERA watchdog that aborts the frame and pulses erro_tx.
module trena_sequenciador_envio #(
  parameter int         N_DIGITOS         = 3,
  parameter logic [7:0] TERMINADOR        = 8'h23,
  parameter logic [7:0] TERMINADOR_ALERTA = 8'h21,
  parameter int         TIMEOUT_CICLOS    = 50000
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   transmitir,
  input  logic                   alerta,
  input  logic [4*N_DIGITOS-1:0] medida,
  input  logic                   tx_pronto,
  output logic                   tx_partida,
  output logic [7:0]             tx_dado,
  output logic                   envio_pronto,
  output logic                   fim_transmissao,
  output logic                   erro_tx,
  output logic [2:0]             db_indice,
  output logic [2:0]             db_estado
);

  localparam int         MW       = 4 * N_DIGITOS;
  localparam logic [2:0] IDX_FIM  = 3'(N_DIGITOS);

  if (N_DIGITOS < 1 || N_DIGITOS > 6) begin : g_chk_digitos
    $error("N_DIGITOS must be in 1..6");
  end
  if (TIMEOUT_CICLOS < 2) begin : g_chk_timeout
    $error("TIMEOUT_CICLOS must be at least 2");
  end

  typedef enum logic [2:0] {
    OCIOSO  = 3'd0,
    PARTIDA = 3'd1,
    ESPERA  = 3'd2,
    CONCLUI = 3'd3
  } estado_t;

  // Digits map to '0'..'9', non-BCD nibbles to '?', and the slot after the last digit to the terminator.
  function automatic logic [7:0] caractere(input logic [MW-1:0] m, input logic alerta_f,
                                           input logic [2:0] idx);
    logic [3:0] nib;
    nib       = 4'd0;
    caractere = alerta_f ? TERMINADOR_ALERTA : TERMINADOR;
    for (int k = 0; k < N_DIGITOS; k++) begin
      if (idx == 3'(k)) begin
        nib       = m[4*(N_DIGITOS-1-k) +: 4];
        caractere = (nib > 4'd9) ? 8'h3F : (8'h30 + {4'h0, nib});
      end
    end
  endfunction

  estado_t        estado_q, estado_d;
  logic [2:0]     indice_q, indice_d;
  logic [MW-1:0]  medida_q, medida_d;
  logic           alerta_q, alerta_d;
  logic [7:0]     dado_q, dado_d;
  logic           partida_q, partida_d;
  logic           envio_q, envio_d;
  logic           fim_q, fim_d;
`ifdef TIMEOUT_TX_EN
  localparam int             CNT_W  = $clog2(TIMEOUT_CICLOS);
  localparam logic [CNT_W-1:0] LIMITE = CNT_W'(TIMEOUT_CICLOS - 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             erro_q, erro_d;
`endif

  // Next-state and next-output computation.
  always_comb begin
    estado_d  = estado_q;
    indice_d  = indice_q;
    medida_d  = medida_q;
    alerta_d  = alerta_q;
    dado_d    = dado_q;
    partida_d = 1'b0;
    envio_d   = 1'b0;
    fim_d     = 1'b0;
`ifdef TIMEOUT_TX_EN
    cnt_d     = '0;
    erro_d    = 1'b0;
`endif
    case (estado_q)
      OCIOSO: begin
        if (transmitir) begin
          estado_d  = PARTIDA;
          partida_d = 1'b1;
          // The first character of a frame uses the live inputs, which are latched at the same edge.
          if (indice_q == 3'd0) begin
            medida_d = medida;
            alerta_d = alerta;
            dado_d   = caractere(medida, alerta, indice_q);
          end else begin
            dado_d   = caractere(medida_q, alerta_q, indice_q);
          end
        end else begin
          estado_d = OCIOSO;
        end
      end
      PARTIDA: begin
        estado_d = ESPERA;
      end
      ESPERA: begin
        if (tx_pronto) begin
          estado_d = CONCLUI;
          if (indice_q == IDX_FIM) begin
            fim_d = 1'b1;
          end else begin
            envio_d = 1'b1;
          end
        end
`ifdef TIMEOUT_TX_EN
        else if (cnt_q == LIMITE) begin
          estado_d = OCIOSO;
          indice_d = 3'd0;
          erro_d   = 1'b1;
          fim_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`else
        else begin
          estado_d = ESPERA;
        end
`endif
      end
      CONCLUI: begin
        estado_d = OCIOSO;
        indice_d = (indice_q == IDX_FIM) ? 3'd0 : (indice_q + 3'd1);
      end
      default: begin
        estado_d = OCIOSO;
        indice_d = 3'd0;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q  <= OCIOSO;
      indice_q  <= 3'd0;
      medida_q  <= '0;
      alerta_q  <= 1'b0;
      dado_q    <= 8'h00;
      partida_q <= 1'b0;
      envio_q   <= 1'b0;
      fim_q     <= 1'b0;
`ifdef TIMEOUT_TX_EN
      cnt_q     <= '0;
      erro_q    <= 1'b0;
`endif
    end else begin
      estado_q  <= estado_d;
      indice_q  <= indice_d;
      medida_q  <= medida_d;
      alerta_q  <= alerta_d;
      dado_q    <= dado_d;
      partida_q <= partida_d;
      envio_q   <= envio_d;
      fim_q     <= fim_d;
`ifdef TIMEOUT_TX_EN
      cnt_q     <= cnt_d;
      erro_q    <= erro_d;
`endif
    end
  end

  assign tx_partida      = partida_q;
  assign tx_dado         = dado_q;
  assign envio_pronto    = envio_q;
  assign fim_transmissao = fim_q;
  assign db_indice       = indice_q;
  assign db_estado       = estado_q;
`ifdef TIMEOUT_TX_EN
  assign erro_tx         = erro_q;
`else
  assign erro_tx         = 1'b0;
`endif

endmodule
